timer_counter: RTL and testbench

- Memory-mapped countdown timer. It is the responder on the device side of the CPU-to-peripheral bridge.
- Two instances are used: TC0 at 0x7f00–0x7f0b and TC1 at 0x7f10–0x7f1b.
- The bridge supplies the word address, write data and write enable. The bridge returns the combinational read data to the CPU and forwards IRQ into HWInt[2] (TC0) or HWInt[3] (TC1).
- Only word accesses arrive here. Byte/half accesses, COUNT stores and interrupt-squashed stores are filtered upstream.

---
 rtl/timer_counter.sv | 128 ++++++++++++
 tb/tb_timer_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a masked IRQ.
// Optional build macro TC_PRESET_RESTART_EN: a PRESET write during CNT or INT restarts via LOAD.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  state_t      state, state_nxt;
  logic        enable;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag;
  logic        set_flag, clr_flag, clr_enable;
  logic        ctrl_wr, preset_wr;

  // Addr is the word address A[31:2], so byte-address bits [3:2] sit at Addr[1:0].
  logic [1:0]  reg_sel;
  logic        unused_addr_bits;
  assign reg_sel          = Addr[1:0];
  assign unused_addr_bits = ^Addr[29:2];

  assign ctrl_wr   = WE && (reg_sel == REG_CTRL);
  assign preset_wr = WE && (reg_sel == REG_PRESET);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    set_flag   = 1'b0;
    clr_flag   = 1'b0;
    clr_enable = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = enable ? CNT : IDLE;
      end
      CNT: begin
        if (!enable) begin
          state_nxt = IDLE;
`ifdef TC_PRESET_RESTART_EN
        end else if (preset_wr) begin
          state_nxt = LOAD;
`endif
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          set_flag  = 1'b1;
          state_nxt = INT;
        end
      end
      INT: begin
        // Mode 1 auto-reloads; modes 0, 2 and 3 are one-shot.
        if (mode == 2'd1) begin
          clr_flag  = 1'b1;
          state_nxt = LOAD;
        end else begin
          clr_enable = 1'b1;
          state_nxt  = IDLE;
        end
`ifdef TC_PRESET_RESTART_EN
        if (preset_wr) state_nxt = LOAD;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      enable   <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      // A host CTRL write overrides the FSM's one-shot Enable clear.
      if (ctrl_wr) begin
        enable <= Din[0];
        mode   <= Din[2:1];
        im     <= Din[3];
      end else if (clr_enable) begin
        enable <= 1'b0;
      end
      if (preset_wr) preset <= Din;
      // An FSM expiry beats a same-edge CTRL-write clear.
      if (set_flag)                  irq_flag <= 1'b1;
      else if (ctrl_wr || clr_flag)  irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (reg_sel)
      REG_CTRL:   Dout = {28'd0, im, mode, enable};
      REG_PRESET: Dout = preset;
      REG_COUNT:  Dout = count;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register map, one-shot, auto-reload, masking,
// same-edge priorities, zero preset, PRESET writes while counting and reset mid-count.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7f00;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  // All tasks start and end at a falling edge; wr spans exactly one rising edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    Addr = 30'((BASE + off) >> 2);
    Din  = data;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] val);
    Addr = 30'((BASE + off) >> 2);
    #1;
    val = Dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; WE = 1'b0; Din = 32'd0; Addr = 30'd0;
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_reg off=%0d got %0h exp 0", i * 4, v); end
    end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", IRQ); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      rd(32'h8, v);
      if (k >= 2) begin
        checks++;
        if (v !== 32'(7 - k)) begin errors++; $display("FAIL oneshot_count k=%0d got %0d exp %0d", k, v, 7 - k); end
      end
      checks++;
      if (IRQ !== (k == 7)) begin errors++; $display("FAIL oneshot_irq k=%0d got %b exp %b", k, IRQ, k == 7); end
    end
    tick(3);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold got %b exp 1", IRQ); end
    rd(32'h0, v);
    checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got %0h exp 8", v); end
    wr(32'h0, 32'h8);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got %b exp 0", IRQ); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] v;
    int ph;
    logic [31:0] exp_c;
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      rd(32'h8, v);
      // Period of 5 edges: COUNT 3,2,1,0 then one LOAD cycle holding 0.
      ph    = (k >= 2) ? (k - 2) % 5 : 4;
      exp_c = (ph <= 3) ? 32'(3 - ph) : 32'd0;
      checks++;
      if (v !== exp_c) begin errors++; $display("FAIL reload_count k=%0d got %0d exp %0d", k, v, exp_c); end
      checks++;
      if (IRQ !== (ph == 3)) begin errors++; $display("FAIL reload_irq k=%0d got %b exp %b", k, IRQ, ph == 3); end
    end
    wr(32'h0, 32'h0);
    tick(2);
    rd(32'h8, v);
    checks++;
    if (v !== 32'd3 || IRQ !== 1'b0) begin
      errors++; $display("FAIL reload_stop count %0d irq %b exp 3 0", v, IRQ);
    end
  endtask

  task automatic test_irq_mask();
    logic [31:0] v;
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    tick(4);
    rd(32'h8, v);
    checks++;
    if (v !== 32'd0 || IRQ !== 1'b0) begin
      errors++; $display("FAIL mask_expire count %0d irq %b exp 0 0", v, IRQ);
    end
    tick(1);
    rd(32'h0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mask_ctrl got %0h exp 0", v); end
    wr(32'h0, 32'h9);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_flag_cleared got %b exp 0", IRQ); end
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      checks++;
      if (IRQ !== (k == 4)) begin errors++; $display("FAIL mask_rearm k=%0d got %b exp %b", k, IRQ, k == 4); end
    end
    wr(32'h0, 32'h0);
    tick(1);
  endtask

  task automatic test_same_edge();
    logic [31:0] v;
    wr(32'h4, 32'd1);
    wr(32'h0, 32'h9);
    tick(3);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL same_int_reached got %b exp 1", IRQ); end
    wr(32'h0, 32'h9);
    rd(32'h0, v);
    checks++;
    if (v !== 32'h9 || IRQ !== 1'b0) begin
      errors++; $display("FAIL same_write_wins ctrl %0h irq %b exp 9 0", v, IRQ);
    end
    tick(2);
    wr(32'h0, 32'h9);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL same_set_priority got %b exp 1", IRQ); end
    tick(1);
    rd(32'h0, v);
    checks++;
    if (v !== 32'h8 || IRQ !== 1'b1) begin
      errors++; $display("FAIL same_oneshot_end ctrl %0h irq %b exp 8 1", v, IRQ);
    end
    wr(32'h0, 32'h0);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL same_clear got %b exp 0", IRQ); end
  endtask

  task automatic test_preset_zero();
    logic [31:0] v;
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    tick(2);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL zero_early got %b exp 0", IRQ); end
    tick(1);
    rd(32'h8, v);
    checks++;
    if (IRQ !== 1'b1 || v !== 32'd0) begin
      errors++; $display("FAIL zero_expire irq %b count %0d exp 1 0", IRQ, v);
    end
    wr(32'h0, 32'h0);
    tick(1);
  endtask

  task automatic test_preset_in_cnt();
    logic [31:0] v;
    logic [31:0] exp_c[4];
    logic        exp_i[4];
`ifdef TC_PRESET_RESTART_EN
    exp_c = '{32'd6, 32'd2, 32'd1, 32'd0};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_c = '{32'd5, 32'd4, 32'd3, 32'd2};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    tick(6);
    rd(32'h8, v);
    checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL cnt_before got %0d exp 6", v); end
    wr(32'h4, 32'd2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick(1);
      rd(32'h8, v);
      checks++;
      if (v !== exp_c[k]) begin errors++; $display("FAIL cnt_preset_wr k=%0d got %0d exp %0d", k, v, exp_c[k]); end
      checks++;
      if (IRQ !== exp_i[k]) begin errors++; $display("FAIL cnt_preset_irq k=%0d got %b exp %b", k, IRQ, exp_i[k]); end
    end
    rd(32'h4, v);
    checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL cnt_preset_read got %0d exp 2", v); end
    wr(32'h0, 32'h0);
    tick(2);
  endtask

  task automatic test_midcount_reset();
    logic [31:0] v;
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    tick(4);
    wr(32'h0, 32'h0);
    tick(3);
    rd(32'h8, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL mid_frozen got %0d exp 7", v); end
    wr(32'h8, 32'hFFFF);
    rd(32'h8, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL mid_count_ro got %0d exp 7", v); end
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'hC, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL mid_off_c got %0h exp 0", v); end
    wr(32'h0, 32'hFFFF_FFF0);
    rd(32'h0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL mid_ctrl_upper got %0h exp 0", v); end
    wr(32'h0, 32'h9);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_reg off=%0d got %0h exp 0", i * 4, v); end
    end
    tick(3);
    rd(32'h8, v);
    checks++;
    if (v !== 32'd0 || IRQ !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle count %0d irq %b exp 0 0", v, IRQ);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_irq_mask();
    test_same_edge();
    test_preset_zero();
    test_preset_in_cnt();
    test_midcount_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
